priority_encoder_hs: RTL and testbench

PRIORITY_ENCODER_HS -- requirements
Module: priority_encoder_hs

---
 rtl/priority_encoder_hs.sv | 136 +++++++++++++
 tb/tb_priority_encoder_hs.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_hs.sv
// Captures request lines into a pending set and grants the highest set bit
// through a two-state present/acknowledge handshake, counting requests lost to bits that were already pending.
module priority_encoder_hs #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    input  logic          ack,
    output logic [CW-1:0] code,
    output logic          valid,
    output logic [N-1:0]  pending,
    output logic [3:0]    ovf_cnt
);

    localparam int PW = $clog2(N + 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   code_r;
    logic            valid_r;
    logic [N-1:0]    pending_r;
    logic [3:0]      ovf_cnt_r;

    logic            grant_s;
    logic [CW-1:0]   grant_idx_s;
    logic [N-1:0]    clr_mask_s;
    logic [N-1:0]    pending_next_s;
    logic [N-1:0]    lost_s;
    logic [PW-1:0]   lost_cnt_s;
    logic [5:0]      ovf_sum_s;
    logic [3:0]      ovf_next_s;

    // Highest set bit wins because later iterations overwrite earlier ones.
    function automatic logic [CW-1:0] top_index(input logic [N-1:0] vec);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = CW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [PW-1:0] pop_count(input logic [N-1:0] vec);
        logic [PW-1:0] cnt;
        cnt = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{(PW-1){1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Grant decision, pending-set update and overflow accounting for this edge.
    always_comb begin
        grant_s     = (state_r == IDLE) && (pending_r != {N{1'b0}});
        grant_idx_s = top_index(pending_r);
        clr_mask_s  = {N{1'b0}};
        if (grant_s) begin
            clr_mask_s = {{(N-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            clr_mask_s = {N{1'b0}};
        end

        // Set-wins: OR-ing req after the clear keeps a bit re-requested at its grant edge.
        if (en) begin
            pending_next_s = (pending_r & ~clr_mask_s) | req;
            lost_s         = req & pending_r & ~clr_mask_s;
        end else begin
            pending_next_s = pending_r & ~clr_mask_s;
            lost_s         = {N{1'b0}};
        end

        lost_cnt_s = pop_count(lost_s);
        ovf_sum_s  = {2'b00, ovf_cnt_r} + 6'(lost_cnt_s);
        if (ovf_sum_s > 6'd15) begin
            ovf_next_s = 4'd15;
        end else begin
            ovf_next_s = ovf_sum_s[3:0];
        end
    end

    // Handshake FSM together with the pending set and overflow counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            code_r    <= {CW{1'b0}};
            valid_r   <= 1'b0;
            pending_r <= {N{1'b0}};
            ovf_cnt_r <= 4'd0;
        end else begin
            pending_r <= pending_next_s;
            ovf_cnt_r <= ovf_next_s;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        state_r <= PRESENT;
                        code_r  <= grant_idx_s;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= PRESENT;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign code    = code_r;
    assign valid   = valid_r;
    assign pending = pending_r;
    assign ovf_cnt = ovf_cnt_r;

endmodule

// File: tb/tb_priority_encoder_hs.sv
// Directed bench for priority_encoder_hs: hand-computed expectations checked
// with immediate assertions one cycle-step at a time.
module tb_priority_encoder_hs;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic [3:0] ovf_cnt;

    int checks;
    int failures;

    priority_encoder_hs #(.N(8), .CW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .ack     (ack),
        .code    (code),
        .valid   (valid),
        .pending (pending),
        .ovf_cnt (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_code, input logic e_valid,
                             input logic [7:0] e_pend, input logic [3:0] e_ovf);
        check({tag, ".code"},    32'(code),    32'(e_code));
        check({tag, ".valid"},   32'(valid),   32'(e_valid));
        check({tag, ".pending"}, 32'(pending), 32'(e_pend));
        check({tag, ".ovf"},     32'(ovf_cnt), 32'(e_ovf));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        req      = 8'h00;
        ack      = 1'b0;

        // Reset state, observed before any clock edge
        #1 rst_n = 1'b0;
        #1 check_all("reset", 3'd0, 1'b0, 8'h00, 4'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single request
        en = 1'b1; req = 8'b0000_0100;
        tick(); check_all("single_cap", 3'd0, 1'b0, 8'h04, 4'd0);
        req = 8'h00;
        tick(); check_all("single_grant", 3'd2, 1'b1, 8'h00, 4'd0);
        ack = 1'b1;
        tick(); check_all("single_ack", 3'd2, 1'b0, 8'h00, 4'd0);
        tick(); check("idle_ack_ignored", 32'(valid), 32'd0);
        ack = 1'b0;

        // Priority order 7, 4, 0
        req = 8'b1001_0001;
        tick(); check_all("prio_cap", 3'd2, 1'b0, 8'h91, 4'd0);
        req = 8'h00;
        tick(); check_all("prio_g7", 3'd7, 1'b1, 8'h11, 4'd0);
        ack = 1'b1;
        tick(); check_all("prio_bubble1", 3'd7, 1'b0, 8'h11, 4'd0);
        ack = 1'b0;
        tick(); check_all("prio_g4", 3'd4, 1'b1, 8'h01, 4'd0);
        ack = 1'b1;
        tick(); check_all("prio_bubble2", 3'd4, 1'b0, 8'h01, 4'd0);
        ack = 1'b0;
        tick(); check_all("prio_g0", 3'd0, 1'b1, 8'h00, 4'd0);
        ack = 1'b1;
        tick(); check_all("prio_done", 3'd0, 1'b0, 8'h00, 4'd0);
        ack = 1'b0;

        // Disable
        en = 1'b0; req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("disable", 3'd0, 1'b0, 8'h00, 4'd0);
        end
        en = 1'b1; req = 8'h00;

        // Stability during PRESENT
        req = 8'b0000_0010;
        tick(); check_all("stab_cap", 3'd0, 1'b0, 8'h02, 4'd0);
        req = 8'h00;
        tick(); check_all("stab_grant", 3'd1, 1'b1, 8'h00, 4'd0);
        req = 8'h80;
        tick(); check_all("stab_1", 3'd1, 1'b1, 8'h80, 4'd0);
        req = 8'h40;
        tick(); check_all("stab_2", 3'd1, 1'b1, 8'hC0, 4'd0);
        req = 8'h80;
        tick(); check_all("stab_3", 3'd1, 1'b1, 8'hC0, 4'd1);
        req = 8'h00;
        tick(); check_all("stab_4", 3'd1, 1'b1, 8'hC0, 4'd1);
        tick(); check_all("stab_5", 3'd1, 1'b1, 8'hC0, 4'd1);
        ack = 1'b1;
        tick(); check_all("stab_ack", 3'd1, 1'b0, 8'hC0, 4'd1);
        ack = 1'b0;
        tick(); check_all("stab_g7", 3'd7, 1'b1, 8'h40, 4'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(); check_all("stab_g6", 3'd6, 1'b1, 8'h00, 4'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        // Async reset mid-PRESENT
        req = 8'h20;
        tick(); check_all("rst_cap", 3'd6, 1'b0, 8'h20, 4'd1);
        req = 8'h00;
        tick(); check_all("rst_pre", 3'd5, 1'b1, 8'h00, 4'd1);
        #3 rst_n = 1'b0;
        #1 check_all("rst_async", 3'd0, 1'b0, 8'h00, 4'd0);
        en = 1'b1; req = 8'h08;
        #1 rst_n = 1'b1;

        // Overflow and set-wins with req[3] held
        tick(); check_all("ovf_cap", 3'd0, 1'b0, 8'h08, 4'd0);
        for (int k = 2; k <= 20; k++) begin
            tick();
            check_all("ovf_hold", 3'd3, 1'b1, 8'h08, (k - 2 > 15) ? 4'd15 : 4'(k - 2));
        end
        req = 8'h00; ack = 1'b1;
        tick(); check_all("ovf_ack", 3'd3, 1'b0, 8'h08, 4'd15);
        ack = 1'b0;
        tick(); check_all("ovf_regrant", 3'd3, 1'b1, 8'h00, 4'd15);

        // Simultaneous ack and new request
        ack = 1'b1; req = 8'h01;
        tick(); check_all("ack_req", 3'd3, 1'b0, 8'h01, 4'd15);
        ack = 1'b0; req = 8'h00;
        tick(); check_all("ack_req_grant", 3'd0, 1'b1, 8'h00, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
